// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder_pkg
//  Description : Shared widths and FSM state encoding for the memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_responder_pkg;

    localparam int c_word_width_def = 16;  // default data word width
    localparam int c_addr_width_def = 8;   // default word address width
    localparam int c_wait_cnt_width = 4;   // wait-state counter width (0..15)

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

endpackage : mem_responder_pkg
`default_nettype wire

// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder_if
//  Description : Request/response handshake bundle between an initiator
//                (master) and the memory responder (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_responder_if
    import mem_responder_pkg::*;
#(
    parameter int MEM_WORD_WIDTH = c_word_width_def,
    parameter int MEM_ADDR_WIDTH = c_addr_width_def
) ();

    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic [MEM_ADDR_WIDTH-1:0] req_addr;
    logic [MEM_WORD_WIDTH-1:0] req_wdata;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [MEM_WORD_WIDTH-1:0] rsp_rdata;
    logic                      rsp_ok;
    logic                      busy_clear;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_ok, busy_clear
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_ok, busy_clear
    );

endinterface : mem_responder_if
`default_nettype wire

// File: rtl/mem_responder_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : mem_array
//  Description : Single-port DEPTH x WORD_WIDTH storage, synchronous write and
//                registered read. Read data holds until the next read enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int WORD_WIDTH = c_word_width_def,
    parameter int DEPTH      = 256,
    parameter int IDX_WIDTH  = 8
) (
    input  wire logic                  clk,
    input  wire logic                  wr_en,
    input  wire logic                  rd_en,
    input  wire logic [IDX_WIDTH-1:0]  addr,
    input  wire logic [WORD_WIDTH-1:0] wdata,
    output logic      [WORD_WIDTH-1:0] rdata
);

    logic [WORD_WIDTH-1:0] mem_q [DEPTH];
    logic [WORD_WIDTH-1:0] rdata_q;

    // Storage has no reset: zeroing is done word by word by the owner.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[addr] <= wdata;
        end
        if (rd_en) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule : mem_array
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Valid/ready memory responder. Clears its storage after reset,
//                then serves one read or write at a time with a fixed number
//                of wait states and an out-of-range error response.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int MEM_WORD_WIDTH = c_word_width_def,
    parameter int MEM_ADDR_WIDTH = c_addr_width_def,
    parameter int DEPTH          = 256,
    parameter int WAIT_CYCLES    = 2
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    mem_responder_if.slave  bus
);

    localparam int c_idx_width = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [MEM_ADDR_WIDTH-1:0]   c_last_addr = MEM_ADDR_WIDTH'(DEPTH - 1);
    localparam logic [MEM_ADDR_WIDTH-1:0]   c_addr_one  = MEM_ADDR_WIDTH'(1);
    localparam logic [MEM_ADDR_WIDTH:0]     c_depth     = (MEM_ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [c_wait_cnt_width-1:0] c_wait_init = c_wait_cnt_width'(WAIT_CYCLES);
    localparam logic [c_wait_cnt_width-1:0] c_wait_one  = c_wait_cnt_width'(1);

    state_e                      state_q,    state_d;
    logic [MEM_ADDR_WIDTH-1:0]   clr_cnt_q,  clr_cnt_d;
    logic [c_wait_cnt_width-1:0] wait_cnt_q, wait_cnt_d;
    logic                        write_q,    write_d;
    logic [MEM_ADDR_WIDTH-1:0]   addr_q,     addr_d;
    logic [MEM_WORD_WIDTH-1:0]   wdata_q,    wdata_d;

    logic                        in_range;
    logic                        mem_wr_en;
    logic                        mem_rd_en;
    logic [c_idx_width-1:0]      mem_idx;
    logic [MEM_WORD_WIDTH-1:0]   mem_wdata;
    logic [MEM_WORD_WIDTH-1:0]   mem_rdata;

    // Unsigned compare one bit wider so DEPTH == 2**MEM_ADDR_WIDTH never wraps.
    assign in_range = ({1'b0, addr_q} < c_depth);

    // State and captured-request registers; memory contents are untouched here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            clr_cnt_q  <= '0;
            wait_cnt_q <= '0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d        = state_q;
        clr_cnt_d      = clr_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        write_d        = write_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        bus.req_ready  = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.rsp_ok     = 1'b0;
        bus.rsp_rdata  = '0;
        bus.busy_clear = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                bus.busy_clear = 1'b1;
                if (clr_cnt_q == c_last_addr) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + c_addr_one;
                end
            end
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    write_d    = bus.req_write;
                    addr_d     = bus.req_addr;
                    wdata_d    = bus.req_wdata;
                    wait_cnt_d = c_wait_init;
                    state_d    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // The memory operation is issued on the edge that leaves ACCESS.
                if (wait_cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - c_wait_one;
                end
            end
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_ok    = in_range;
                bus.rsp_rdata = (in_range && !write_q) ? mem_rdata : '0;
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // Memory port steering: clear sweep, or the single access at end of ACCESS.
    always_comb begin
        mem_wr_en = 1'b0;
        mem_rd_en = 1'b0;
        mem_idx   = c_idx_width'(addr_q);
        mem_wdata = wdata_q;
        if (state_q == ST_CLEAR) begin
            mem_wr_en = 1'b1;
            mem_idx   = c_idx_width'(clr_cnt_q);
            mem_wdata = '0;
        end else if ((state_q == ST_ACCESS) && (wait_cnt_q == '0) && in_range) begin
            mem_wr_en = write_q;
            mem_rd_en = !write_q;
        end
    end

    mem_array #(
        .WORD_WIDTH (MEM_WORD_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_WIDTH  (c_idx_width)
    ) u_mem_array (
        .clk   (clk),
        .wr_en (mem_wr_en),
        .rd_en (mem_rd_en),
        .addr  (mem_idx),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

endmodule : mem_responder
`default_nettype wire

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORD_WIDTH, default 16, meaning data word width.
REQ-002 SHALL have parameter MEM_ADDR_WIDTH, default 8, meaning address width.
REQ-003 SHALL have parameter DEPTH, default 256 (max 2**MEM_ADDR_WIDTH), meaning number of implemented words.
REQ-004 SHALL have parameter WAIT_CYCLES, default 2 (range 0..15), meaning access wait states.
REQ-005 SHALL have port clk, input, 1, meaning the single clock, rising edge active.
REQ-006 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port req_valid, input, 1, meaning the initiator presents a request.
REQ-008 SHALL have port req_ready, output, 1, meaning the responder accepts a request this cycle.
REQ-009 SHALL have port req_write, input, 1, meaning 1 = write and 0 = read.
REQ-010 SHALL have port req_addr, input, MEM_ADDR_WIDTH, meaning the word address.
REQ-011 SHALL have port req_wdata, input, MEM_WORD_WIDTH, meaning the write data.
REQ-012 SHALL have port rsp_valid, output, 1, meaning a response is presented.
REQ-013 SHALL have port rsp_ready, input, 1, meaning the initiator consumes the response.
REQ-014 SHALL have port rsp_rdata, output, MEM_WORD_WIDTH, meaning the read data (0 for writes and errors).
REQ-015 SHALL have port rsp_ok, output, 1, meaning the operation succeeded (Mem_op_success equivalent).
REQ-016 SHALL have port busy_clear, output, 1, meaning the post-reset memory clear is in progress.

Function
REQ-017 SHALL implement a 4-state FSM: CLEAR, IDLE, ACCESS, RESP.
REQ-018 In CLEAR, SHALL write 0 to one word per cycle at addresses 0..DEPTH-1, then go to IDLE; busy_clear=1 throughout, req_ready=0.
REQ-019 SHALL drive req_ready=1 only in IDLE; a request is accepted on a clk edge where req_valid&&req_ready.
REQ-020 On acceptance, SHALL capture write, addr and wdata into internal registers; later changes to the req_* inputs have no effect.
REQ-021 SHALL enter ACCESS and stay WAIT_CYCLES cycles, counted by a 4-bit down-counter; WAIT_CYCLES=0 goes directly to RESP the next cycle.
REQ-022 On leaving ACCESS, SHALL perform the memory operation: a write updates the word; a read loads rsp_rdata.
REQ-023 Accept-to-rsp_valid latency SHALL be WAIT_CYCLES+1 cycles.
REQ-024 In RESP, SHALL hold rsp_valid=1 and stable rsp_rdata/rsp_ok until rsp_ready=1, then return to IDLE on that edge.
REQ-025 If rsp_ready is already 1 when rsp_valid rises, SHALL return to IDLE on the next edge; a new request is accepted no earlier than one cycle after the response handshake.
REQ-026 For captured addr >= DEPTH, SHALL perform no write, set rsp_rdata=0 and rsp_ok=0, with the same latency.
REQ-027 For a valid read, SHALL set rsp_ok=1; for a valid write, SHALL set rsp_ok=1 and rsp_rdata=0.
REQ-028 Outside RESP, SHALL drive rsp_valid=0, rsp_ok=0 and rsp_rdata=0.
REQ-029 A read issued after a write to the same address SHALL return the written data (no stale data).
REQ-030 Address arithmetic SHALL be unsigned with no wrap-around; the clear counter stops at DEPTH-1.

Reset
REQ-031 On rst_n=0, independent of clk, SHALL force state=CLEAR, clear counter=0, req_ready=0, rsp_valid=0, rsp_ok=0, rsp_rdata=0 and busy_clear=1.
REQ-032 Reset asserted during ACCESS or RESP SHALL abandon the operation with no partial write; after rst_n release the whole memory is re-cleared.
REQ-033 Memory contents SHALL NOT be reset asynchronously; zeroing happens only via the CLEAR state.

Structure
REQ-034 Width constants and the FSM state encoding SHALL live in the shared architecture header alongside MEM_WORD_WIDTH and MEM_ADDR_WIDTH.
REQ-035 Storage SHALL be a sub-module mem_array: single-port, synchronous write, synchronous read, DEPTH x MEM_WORD_WIDTH; the FSM and counters stay in mem_responder.

Verification
REQ-036 Reset release, DEPTH=256 -> busy_clear=1 for 256 cycles then req_ready=1; reads of addresses 0x00 and 0xFF return 0x0000 with ok=1.
REQ-037 Write 0xBEEF to 0x10, then read 0x10, WAIT_CYCLES=2 -> write rsp_ok=1; read rsp_valid 3 cycles after accept, rdata=0xBEEF.
REQ-038 DEPTH=128, read 0x80 and write 0x90 -> rsp_ok=0, rdata=0; a later read of 0x10 (written 0x1234) still returns 0x1234.
REQ-039 Hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid and rdata stay stable and req_ready=0; on rsp_ready=1, IDLE follows the next cycle.
REQ-040 Assert rst_n=0 mid-ACCESS of a write of 0x5555 to 0x20 -> outputs go to reset values immediately; after re-clear, a read of 0x20 returns 0x0000.
REQ-041 WAIT_CYCLES=0 with back-to-back requests and rsp_ready tied 1 -> each response arrives 1 cycle after accept and requests are accepted every 3 cycles.
